// File: rtl/nios2_pio_in_pkg.sv
// Shared definitions for the Nios II PIO input block: register offsets and edge modes.
package nios2_pio_in_pkg;

   typedef enum logic [1:0] {
      RISING  = 2'd0,
      FALLING = 2'd1,
      ANY     = 2'd2
   } edge_mode_t;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

endpackage

// File: rtl/nios2_pio_debounce.sv
// One input bit: 2-flop synchronizer followed by an optional stable-count debouncer.
module nios2_pio_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic sync_meta;
   logic sync_q;

   // Bring the asynchronous pin into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= din;
         sync_q    <= sync_meta;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign dout = sync_q;
      end else begin : g_count
         localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic          stable;
         logic [CW-1:0] cnt;

         // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               stable <= 1'b0;
               cnt    <= '0;
            end else if (sync_q == stable) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               stable <= sync_q;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         assign dout = stable;
      end
   endgenerate

endmodule

// File: rtl/nios2_pio_in_irq.sv
// Avalon-MM PIO input port with debounce, edge capture and masked level interrupt.
module nios2_pio_in_irq
   import nios2_pio_in_pkg::*;
#(
   parameter int unsigned WIDTH           = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 0,
   parameter edge_mode_t  EDGE_MODE       = RISING
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] db_d;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] ec_clr;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [31:0]      rd_next;

   // Reads have no side effects and readdata is refreshed every cycle, so the
   // read strobe and the upper write-data bits carry no information here.
   logic unused_bus;
   assign unused_bus = &{1'b0, read, writedata};

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .din   (in_port[i]),
         .dout  (db[i])
      );
   end

   // Edge detect against the previous debounced value, per configured mode.
   always_comb begin
      edge_hit = '0;
      case (EDGE_MODE)
         RISING:  edge_hit = db & ~db_d;
         FALLING: edge_hit = ~db & db_d;
         default: edge_hit = db ^ db_d;
      endcase
   end

   // Write-1-to-clear mask for edgecapture, and the read mux.
   always_comb begin
      ec_clr  = '0;
      rd_next = '0;
      if (write && (address == ADDR_EDGECAP)) ec_clr = writedata[WIDTH-1:0];
      case (address)
         ADDR_DATA:    rd_next[WIDTH-1:0] = db;
         ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
         default:      rd_next = '0;
      endcase
   end

   // Register state; a new edge wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_d     <= '0;
         irqmask  <= '0;
         edgecap  <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         db_d     <= db;
         edgecap  <= (edgecap & ~ec_clr) | edge_hit;
         readdata <= rd_next;
         irq      <= |(edgecap & irqmask);
         if (write && (address == ADDR_IRQMASK)) irqmask <= writedata[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_nios2_pio_in_irq.sv
// Bench for nios2_pio_in_irq: three configurations against a history-based model.
module tb_nios2_pio_in_irq;
   import nios2_pio_in_pkg::*;

   localparam int W  = 10;
   localparam int HD = 8;
   localparam int         NDB  [3] = '{0, 4, 0};
   localparam edge_mode_t MODE [3] = '{RISING, RISING, FALLING};

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] rd    [3];
   logic        irq_o [3];
   logic [W-1:0] inp  [3];

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // model state
   logic [W-1:0] hist   [3][HD];
   logic [W-1:0] m_db   [3];
   logic [W-1:0] m_dbp  [3];
   logic [W-1:0] m_ec   [3];
   logic [W-1:0] m_mask [3];
   logic [W-1:0] m_rd   [3];
   logic         m_irq  [3];

   always #5 clk = ~clk;

   nios2_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_MODE(RISING)) u_dut0 (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd[0]), .in_port(inp[0]), .irq(irq_o[0]));

   nios2_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_MODE(RISING)) u_dut4 (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd[1]), .in_port(inp[1]), .irq(irq_o[1]));

   nios2_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_MODE(FALLING)) u_dutf (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd[2]), .in_port(inp[2]), .irq(irq_o[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1;
      step(1);
      write = 1'b0;
   endtask

   // Model: hist[i][j] is the pin value sampled j+1 edges ago; the debounced
   // level flips once the last NDB synchronized samples all disagree with it.
   always @(posedge clk or posedge reset) begin
      logic [W-1:0] n_db, ed, clr, n_rd;
      logic flip;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            m_db[i] = '0; m_dbp[i] = '0; m_ec[i] = '0; m_mask[i] = '0;
            m_rd[i] = '0; m_irq[i] = 1'b0;
            for (int j = 0; j < HD; j++) hist[i][j] = '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_db = m_db[i];
            if (NDB[i] == 0) n_db = hist[i][0];
            else begin
               for (int b = 0; b < W; b++) begin
                  flip = 1'b1;
                  for (int j = 1; j <= NDB[i]; j++)
                     if (hist[i][j][b] == m_db[i][b]) flip = 1'b0;
                  if (flip) n_db[b] = ~m_db[i][b];
               end
            end
            case (MODE[i])
               RISING:  ed = m_db[i] & ~m_dbp[i];
               FALLING: ed = ~m_db[i] & m_dbp[i];
               default: ed = m_db[i] ^ m_dbp[i];
            endcase
            clr = (write && address == 2'd3) ? writedata[W-1:0] : '0;
            case (address)
               2'd0:    n_rd = m_db[i];
               2'd2:    n_rd = m_mask[i];
               2'd3:    n_rd = m_ec[i];
               default: n_rd = '0;
            endcase
            m_irq[i] = |(m_ec[i] & m_mask[i]);
            m_rd[i]  = n_rd;
            m_ec[i]  = (m_ec[i] & ~clr) | ed;
            if (write && address == 2'd2) m_mask[i] = writedata[W-1:0];
            m_dbp[i] = m_db[i];
            m_db[i]  = n_db;
            for (int j = HD - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = inp[i];
         end
      end
   end

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("readdata[%0d]", i), rd[i], {22'b0, m_rd[i]});
            chk($sformatf("irq[%0d]", i), {31'b0, irq_o[i]}, {31'b0, m_irq[i]});
         end
      end
   end

   initial begin
      reset = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0; writedata = '0;
      for (int i = 0; i < 3; i++) inp[i] = '0;
      step(3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_rd[%0d]", i), rd[i], 32'h0);
         chk($sformatf("reset_irq[%0d]", i), {31'b0, irq_o[i]}, 32'h0);
      end
      reset = 1'b0;
      chk_en = 1'b1;

      // plain read of synchronized data
      inp[0] = 10'h155; address = 2'd0; read = 1'b1;
      step(4);
      chk("data_155", rd[0], 32'h155);
      read = 1'b0;
      address = 2'd3; step(2);
      chk("ec_155", rd[0], 32'h155);
      wr(2'd3, 32'h3FF);

      // debounce: 3-cycle pulse rejected, long hold accepted
      address = 2'd0;
      inp[1] = 10'h008; step(3); inp[1] = '0; step(12);
      chk("glitch_data", rd[1], 32'h0);
      address = 2'd3; step(2);
      chk("glitch_ec", rd[1], 32'h0);
      address = 2'd0;
      inp[1] = 10'h008; step(12);
      chk("hold_data", rd[1], 32'h8);
      address = 2'd3; step(2);
      chk("hold_ec", rd[1], 32'h8);

      // masked interrupt and write-1-to-clear
      wr(2'd3, 32'h8);
      wr(2'd2, 32'h8);
      inp[1] = '0; step(12);
      inp[1] = 10'h008; step(12);
      chk("irq_set", {31'b0, irq_o[1]}, 32'h1);
      address = 2'd3; writedata = 32'h8; write = 1'b1;
      step(1);
      write = 1'b0;
      chk("irq_lag", {31'b0, irq_o[1]}, 32'h1);
      step(1);
      chk("irq_clr", {31'b0, irq_o[1]}, 32'h0);
      chk("ec_clr", rd[1], 32'h0);

      // set beats clear on the same bit
      wr(2'd3, 32'h3FF);
      inp[0] = 10'h154; step(5);
      wr(2'd3, 32'h3FF);
      address = 2'd3;
      inp[0] = 10'h155; step(2);
      writedata = 32'h1; write = 1'b1;
      step(1);
      write = 1'b0;
      step(2);
      chk("set_priority", rd[0], 32'h1);

      // falling-edge instance
      wr(2'd3, 32'h3FF);
      inp[2] = 10'h020; step(5);
      inp[2] = '0; step(5);
      address = 2'd3; step(2);
      chk("falling_ec", rd[2], 32'h20);

      // reset mid-debounce with irq high
      wr(2'd3, 32'h3FF);
      inp[1] = '0; step(12);
      inp[1] = 10'h004; step(12);
      wr(2'd2, 32'h4);
      step(2);
      chk("pre_reset_irq", {31'b0, irq_o[1]}, 32'h1);
      address = 2'd0;
      inp[1] = 10'h00C; step(4);
      #1 reset = 1'b1;
      #1;
      chk("async_irq", {31'b0, irq_o[1]}, 32'h0);
      chk("async_rd", rd[1], 32'h0);
      #1 reset = 1'b0;
      step(6);
      chk("restart_early", rd[1], 32'h0);
      step(1);
      chk("restart_done", rd[1], 32'hC);

      // randomized traffic
      repeat (3000) begin
         for (int i = 0; i < 3; i++)
            for (int b = 0; b < W; b++)
               if ($urandom_range(0, 19) == 0) inp[i][b] = ~inp[i][b];
         address   = 2'($urandom_range(0, 3));
         write     = ($urandom_range(0, 3) == 0);
         read      = 1'($urandom_range(0, 1));
         writedata = $urandom;
         if ($urandom_range(0, 599) == 0) begin
            #1 reset = 1'b1;
            #1 reset = 1'b0;
         end
         step(1);
      end
      write = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nios2_pio_in_irq.md
NIOS2_PIO_IN_IRQ -- requirements
Module: nios2_pio_in_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 10: input port width, legal 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 0: stable-cycle count per bit; 0 bypasses debounce, legal 0..65535.
REQ-003 SHALL have parameter EDGE_MODE, default RISING: RISING, FALLING or ANY, for edge capture.
REQ-004 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port address  in  2  Avalon-MM word offset.
REQ-007 SHALL have port read  in  1  Avalon read strobe.
REQ-008 SHALL have port write  in  1  Avalon write strobe.
REQ-009 SHALL have port writedata  in  32  Avalon write data.
REQ-010 SHALL have port readdata  out  32  registered read data, upper 32-WIDTH bits zero.
REQ-011 SHALL have port in_port  in  WIDTH  asynchronous external inputs (switches).
REQ-012 SHALL have port irq  out  1  level interrupt to Nios II.

Function
REQ-013 SHALL pass each in_port bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL, when DEBOUNCE_CYCLES=0, use the synchronized value directly as the debounced value.
REQ-015 SHALL, when DEBOUNCE_CYCLES>0, keep a per-bit counter that clears whenever the synchronized bit equals the stable bit.
REQ-016 SHALL increment that counter while the synchronized bit differs from the stable bit; at count DEBOUNCE_CYCLES-1 the stable bit takes the new value and the counter clears.
REQ-017 SHALL restart the count from zero on any glitch shorter than DEBOUNCE_CYCLES cycles, leaving the stable bit unchanged.
REQ-018 SHALL detect edges on the debounced value against its 1-cycle-delayed copy, per EDGE_MODE.
REQ-019 SHALL implement register map: 0 = data (debounced value, RO); 1 = reserved (reads 0, writes ignored); 2 = irqmask (RW, WIDTH bits); 3 = edgecapture (read; write-1-to-clear).
REQ-020 SHALL register readdata every cycle from the address mux, giving read latency exactly 1 cycle; reads have no side effects.
REQ-021 SHALL set an edgecapture bit on a detected edge; a bit stays set until software clears it.
REQ-022 SHALL give set priority when an edge and a write-1-to-clear hit the same bit in the same cycle (bit stays 1).
REQ-023 SHALL ignore writedata bits above WIDTH-1; writes to address 0 and 1 have no effect.
REQ-024 SHALL drive irq = OR of (edgecapture AND irqmask), registered, asserting 1 cycle after the capture bit is set.
REQ-025 SHALL deassert irq 1 cycle after the last contributing bit is cleared or masked.

Reset
REQ-026 SHALL clear synchronizers, stable values, delayed copies, counters, irqmask, edgecapture, readdata and irq to 0 immediately on reset assertion.
REQ-027 SHALL resume operation on the first clk edge after reset deasserts.
REQ-028 SHALL let an input held high through reset produce one RISING/ANY capture once it passes the synchronizer and debounce; this behaviour is intended.
REQ-029 SHALL, on reset mid-debounce, discard the partial count.

Structure
REQ-030 SHALL place register offsets (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the EDGE_MODE enumeration in package nios2_pio_in_pkg.
REQ-031 SHALL implement the per-bit synchronizer plus debounce counter as sub-module nios2_pio_debounce, instantiated WIDTH times via generate.

Verification
REQ-032 SHALL verify: WIDTH=10, DEBOUNCE_CYCLES=0, in_port=10'h155, read address 0 -> readdata=32'h155 one cycle after the read, once the synchronizer settles (3 cycles).
REQ-033 SHALL verify: DEBOUNCE_CYCLES=4, bit 3 pulsed high for 3 cycles -> data bit 3 stays 0 and no capture; held for 6 cycles -> data bit 3=1 and edgecapture=10'h008.
REQ-034 SHALL verify: irqmask=10'h008, rising edge on bit 3 -> irq=1 one cycle after capture; write 32'h8 to address 3 -> edgecapture=0 and irq=0 one cycle later.
REQ-035 SHALL verify: edge on bit 0 in the same cycle as a write of 32'h1 to address 3 -> edgecapture bit 0 remains 1.
REQ-036 SHALL verify: EDGE_MODE=FALLING, bit 5 toggled 0->1->0 -> only the 1->0 transition captures (edgecapture=10'h020).
REQ-037 SHALL verify: reset asserted mid-debounce with irq high -> irq, readdata and edgecapture drop to 0 with no clock; after release, debounce restarts from zero.
